// File: rtl/dcache_repl_ctrl.sv
// Victim-way selector for a 2-way data cache.
// Keeps one LRU bit per set, answers refill victim requests through a
// req/ready + valid/ack handshake, and sweeps every set on reset or flush
// to invalidate the tag array and clear the LRU table.
module dcache_repl_ctrl #(
  parameter int unsigned addr_width = 4,
  parameter int unsigned way        = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     hit_valid,
  input  logic [addr_width-1:0]    hit_addr,
  input  logic [$clog2(way)-1:0]   hit_way,
  input  logic                     alloc_req,
  input  logic [addr_width-1:0]    alloc_addr,
  output logic                     alloc_ready,
  output logic                     alloc_valid,
  output logic [$clog2(way)-1:0]   alloc_way,
  input  logic                     alloc_ack,
  input  logic                     flush_req,
  output logic                     inv_valid,
  output logic [addr_width-1:0]    inv_addr,
  output logic                     busy
);

  localparam int unsigned way_w    = $clog2(way);
  localparam int unsigned num_sets = 1 << addr_width;

  localparam logic [1:0] SWEEP = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [addr_width-1:0] cnt_last = '1;

  logic [1:0]            state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [way_w-1:0]      alloc_way_q, alloc_way_d;
  logic [num_sets-1:0]   lru_q;

  logic                  hit_we_c;
  logic                  alloc_we_c;
  logic                  clr_we_c;
  logic                  bypass_c;
  logic [way_w-1:0]      victim_c;

  // Victim choice, with a same-cycle hit on the same set overriding the table
  always_comb begin
    bypass_c = hit_valid && (hit_addr == alloc_addr);
    victim_c = bypass_c ? ~hit_way : way_w'(lru_q[alloc_addr]);
  end

  // Next-state, counter/flag updates, table write enables and output decodes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    alloc_way_d = alloc_way_q;
    hit_we_c    = 1'b0;
    alloc_we_c  = 1'b0;
    clr_we_c    = 1'b0;
    inv_valid   = 1'b0;
    busy        = 1'b0;
    alloc_ready = 1'b0;
    alloc_valid = 1'b0;

    case (state_q)
      SWEEP: begin
        inv_valid = 1'b1;
        busy      = 1'b1;
        clr_we_c  = 1'b1;
        cnt_d     = cnt_q + addr_width'(1);
        if (cnt_q == cnt_last) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        alloc_ready = 1'b1;
        hit_we_c    = hit_valid;
        if (alloc_req) begin
          state_d     = RESP;
          alloc_way_d = victim_c;
          alloc_we_c  = 1'b1;
          if (flush_req) begin
            pend_d = 1'b1;
          end
        end else if (flush_req || pend_q) begin
          state_d = SWEEP;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      RESP: begin
        alloc_valid = 1'b1;
        hit_we_c    = hit_valid;
        if (flush_req) begin
          pend_d = 1'b1;
        end
        if (alloc_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  assign alloc_way = alloc_way_q;
  assign inv_addr  = cnt_q;

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SWEEP;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      alloc_way_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      alloc_way_q <= alloc_way_d;
    end
  end

  // LRU table; the alloc write is applied last so it wins on a same-set collision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lru_q <= '0;
    end else begin
      if (clr_we_c) begin
        lru_q[cnt_q] <= 1'b0;
      end
      if (hit_we_c) begin
        lru_q[hit_addr] <= ~hit_way[0];
      end
      if (alloc_we_c) begin
        lru_q[alloc_addr] <= ~victim_c[0];
      end
    end
  end

endmodule

// File: tb/tb_dcache_repl_ctrl.sv
// Directed bench for dcache_repl_ctrl with an LRU reference model and a
// victim-way scoreboard.
module tb_dcache_repl_ctrl;

  logic       clk;
  logic       rstn;
  logic       hit_valid;
  logic [3:0] hit_addr;
  logic       hit_way;
  logic       alloc_req;
  logic [3:0] alloc_addr;
  logic       alloc_ready;
  logic       alloc_valid;
  logic       alloc_way;
  logic       alloc_ack;
  logic       flush_req;
  logic       inv_valid;
  logic [3:0] inv_addr;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  logic lru_m [16];
  logic exp_q [$];

  dcache_repl_ctrl #(.addr_width(4), .way(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .hit_valid   (hit_valid),
    .hit_addr    (hit_addr),
    .hit_way     (hit_way),
    .alloc_req   (alloc_req),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .alloc_valid (alloc_valid),
    .alloc_way   (alloc_way),
    .alloc_ack   (alloc_ack),
    .flush_req   (flush_req),
    .inv_valid   (inv_valid),
    .inv_addr    (inv_addr),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 16; s++) lru_m[s] = 1'b0;
  endtask

  // Walks a full sweep starting at the current cycle; optionally pulses flush mid-sweep
  task automatic sweep_check(input string tag, input bit flush_in);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_inv"}, 32'(inv_valid), 32'd1);
      chk({tag, "_addr"}, 32'(inv_addr), 32'(i));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy0"}, 32'(alloc_ready), 32'd0);
      flush_req = flush_in && (i == 3);
      @(negedge clk);
    end
    flush_req = 1'b0;
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_rdy"}, 32'(alloc_ready), 32'd1);
    chk({tag, "_done_inv"}, 32'(inv_valid), 32'd0);
    clear_model();
  endtask

  task automatic do_hit(input logic [3:0] a, input logic w);
    hit_valid = 1'b1;
    hit_addr  = a;
    hit_way   = w;
    lru_m[a]  = ~w;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  // Issues one alloc from IDLE, optionally with a same-cycle hit, a delayed ack
  // while the requester keeps asserting, and a flush pulse inside the wait window
  task automatic do_alloc(input string tag, input logic [3:0] a, input logic hv,
                          input logic [3:0] ha, input logic hw, input int delay,
                          input bit flush_mid);
    logic v;
    chk({tag, "_rdy"}, 32'(alloc_ready), 32'd1);
    alloc_req  = 1'b1;
    alloc_addr = a;
    hit_valid  = hv;
    hit_addr   = ha;
    hit_way    = hw;
    v = (hv && (ha == a)) ? ~hw : lru_m[a];
    if (hv) lru_m[ha] = ~hw;
    lru_m[a] = ~v;
    exp_q.push_back(v);
    @(negedge clk);
    hit_valid  = 1'b0;
    alloc_req  = (delay > 0);
    alloc_addr = a ^ 4'h1;
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_hold_vld"}, 32'(alloc_valid), 32'd1);
      chk({tag, "_hold_way"}, 32'(alloc_way), 32'(exp_q[0]));
      chk({tag, "_hold_rdy"}, 32'(alloc_ready), 32'd0);
      flush_req = flush_mid && (i == 1);
      @(negedge clk);
    end
    flush_req = 1'b0;
    alloc_req = 1'b0;
    alloc_ack = 1'b1;
    chk({tag, "_vld"}, 32'(alloc_valid), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=response expected=empty_scoreboard", tag);
    end else begin
      chk({tag, "_way"}, 32'(alloc_way), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    alloc_ack = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    hit_valid  = 1'b0;
    hit_addr   = '0;
    hit_way    = 1'b0;
    alloc_req  = 1'b0;
    alloc_addr = '0;
    alloc_ack  = 1'b0;
    flush_req  = 1'b0;
    clear_model();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_inv", 32'(inv_valid), 32'd1);
    chk("rst_addr", 32'(inv_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdy", 32'(alloc_ready), 32'd0);
    chk("rst_vld", 32'(alloc_valid), 32'd0);
    chk("rst_way", 32'(alloc_way), 32'd0);

    // Boot sweep after reset release
    rstn = 1'b1;
    sweep_check("boot", 1'b0);

    // Plain allocs alternate the victim of a set
    do_alloc("a3a", 4'd3, 1'b0, 4'd0, 1'b0, 0, 1'b0);
    do_alloc("a3b", 4'd3, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    // Hit then alloc, then same-cycle hit + alloc on the same set
    do_hit(4'd5, 1'b0);
    do_alloc("a5", 4'd5, 1'b0, 4'd0, 1'b0, 0, 1'b0);
    do_alloc("a5byp", 4'd5, 1'b1, 4'd5, 1'b1, 0, 1'b0);
    do_alloc("a5chk", 4'd5, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    // Hit and alloc on different sets in the same cycle
    do_alloc("a7h2", 4'd7, 1'b1, 4'd2, 1'b0, 0, 1'b0);
    do_alloc("a2chk", 4'd2, 1'b0, 4'd0, 1'b0, 0, 1'b0);
    do_alloc("a7chk", 4'd7, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    // Ack outside RESP has no effect
    alloc_ack = 1'b1;
    @(negedge clk);
    alloc_ack = 1'b0;
    chk("stray_ack_rdy", 32'(alloc_ready), 32'd1);
    chk("stray_ack_vld", 32'(alloc_valid), 32'd0);

    // Withheld ack with flush in the window: held response, then IDLE, then sweep
    do_alloc("a9wait", 4'd9, 1'b0, 4'd0, 1'b0, 5, 1'b1);
    chk("post_ack_rdy", 32'(alloc_ready), 32'd1);
    chk("post_ack_busy", 32'(busy), 32'd0);
    @(negedge clk);
    sweep_check("flush_resp", 1'b0);
    do_alloc("a9clr", 4'd9, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    // Flush from IDLE, with a flush pulse during the sweep that must be ignored
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    sweep_check("flush_idle", 1'b1);
    @(negedge clk);
    chk("no_restart_rdy", 32'(alloc_ready), 32'd1);
    chk("no_restart_busy", 32'(busy), 32'd0);

    // Reset while a response is outstanding
    do_hit(4'd4, 1'b0);
    alloc_req  = 1'b1;
    alloc_addr = 4'd4;
    @(negedge clk);
    alloc_req = 1'b0;
    chk("resp_pre_vld", 32'(alloc_valid), 32'd1);
    chk("resp_pre_way", 32'(alloc_way), 32'd1);
    rstn = 1'b0;
    #1;
    chk("resp_rst_vld", 32'(alloc_valid), 32'd0);
    chk("resp_rst_way", 32'(alloc_way), 32'd0);
    chk("resp_rst_busy", 32'(busy), 32'd1);
    chk("resp_rst_addr", 32'(inv_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    sweep_check("rst_resp", 1'b0);
    do_alloc("a4clr", 4'd4, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    // Reset mid-sweep at cnt=7 restarts the sweep from set 0
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_addr7", 32'(inv_addr), 32'd7);
    rstn = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(inv_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_rdy", 32'(alloc_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    sweep_check("rst_mid", 1'b0);
    do_alloc("a3final", 4'd3, 1'b0, 4'd0, 1'b0, 0, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_repl_ctrl.md
DCACHE_REPL_CTRL -- requirements
Module: dcache_repl_ctrl

Interface
REQ-001 Parameter addr_width, default 4: set-index width; 2^addr_width sets.
REQ-002 Parameter way, default 2: associativity; only 2 is supported, other values are out of scope.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 hit_valid  input  1  pipeline reports a cache hit this cycle.
REQ-006 hit_addr  input  addr_width  set index of the hit.
REQ-007 hit_way  input  1  way that hit.
REQ-008 alloc_req  input  1  refill engine requests a victim way.
REQ-009 alloc_addr  input  addr_width  set index needing a victim.
REQ-010 alloc_ready  output  1  controller can accept alloc_req this cycle.
REQ-011 alloc_valid  output  1  victim response valid.
REQ-012 alloc_way  output  1  victim way; meaningful only while alloc_valid=1.
REQ-013 alloc_ack  input  1  refill engine consumes the response.
REQ-014 flush_req  input  1  single-cycle request to invalidate the whole cache.
REQ-015 inv_valid  output  1  tag-array invalidate strobe.
REQ-016 inv_addr  output  addr_width  set index to invalidate.
REQ-017 busy  output  1  high while a sweep is in progress.

Function
REQ-018 Table: one LRU bit per set, lru[s] = victim way of set s.
REQ-019 FSM states: SWEEP, IDLE and RESP.
REQ-020 SWEEP: inv_valid=1 and inv_addr=cnt; lru[cnt] is cleared to 0; cnt increments each cycle.
REQ-021 SWEEP exits to IDLE in the cycle after cnt = 2^addr_width-1, so the sweep lasts exactly 2^addr_width cycles and cnt wraps to 0.
REQ-022 In SWEEP: busy=1, alloc_ready=0, hit_valid is ignored, and flush_req is ignored (the sweep is not restarted).
REQ-023 IDLE: alloc_ready=1; alloc_req=1 is accepted and the FSM moves to RESP; otherwise, if flush_req=1 or a flush is pending, the FSM moves to SWEEP with cnt=0.
REQ-024 alloc_req takes priority over flush_req in IDLE; the flush is remembered in a pending flag and taken once the FSM returns to IDLE.
REQ-025 On alloc acceptance, victim v = lru[alloc_addr], or v = ~hit_way if hit_valid=1 and hit_addr=alloc_addr in the same cycle (bypass).
REQ-026 On alloc acceptance, v is registered to alloc_way and lru[alloc_addr] is set to ~v.
REQ-027 Alloc latency: alloc_valid=1 in the cycle after acceptance.
REQ-028 RESP: alloc_valid=1 and alloc_way are held stable until alloc_ack=1, then the FSM moves to IDLE on the next edge; alloc_ready=0 throughout RESP.
REQ-029 In RESP, flush_req sets the pending flag; the flush is executed after the ack.
REQ-030 Hit update (IDLE or RESP, hit_valid=1): lru[hit_addr] is set to ~hit_way.
REQ-031 Simultaneous hit and alloc on the same set: final lru = hit_way (alloc write wins); on different sets both writes apply in the same cycle.
REQ-032 alloc_ack outside RESP is ignored; alloc_req while alloc_ready=0 is not accepted and the requester holds it.

Reset
REQ-033 rstn=0 forces: state=SWEEP, cnt=0, pending flush=0, alloc_valid=0, alloc_way=0, all lru=0.
REQ-034 After rstn rises, a full sweep runs before the first alloc is accepted; reset asserted mid-sweep or mid-RESP aborts immediately to the REQ-033 values.
REQ-035 During reset, inv_valid=1, inv_addr=0, busy=1 and alloc_ready=0, as combinational functions of state.

Verification
REQ-036 Reset release, addr_width=4 -> inv_valid=1 with inv_addr 0..15 over 16 cycles; busy falls and alloc_ready rises on cycle 17.
REQ-037 IDLE, alloc set 3 (lru=0), ack the same cycle as alloc_valid -> alloc_way=0; a second alloc to set 3 -> alloc_way=1.
REQ-038 hit set 5 way 0, then alloc set 5 -> alloc_way=1; hit set 5 way 1 and alloc set 5 in the same cycle -> alloc_way=0 and lru[5]=1.
REQ-039 alloc accepted, ack withheld 5 cycles with flush_req pulsed in that window -> alloc_valid and alloc_way held stable, no second accept; after the ack the FSM goes IDLE and then a 16-cycle sweep runs.
REQ-040 rstn pulsed low at sweep cnt=7 -> the next sweep restarts at inv_addr=0.
